// File: rtl/rs_decoding_cont.sv
// RS(15,9) decoder over GF(16) (x^4+x+1): serial Horner syndromes, single-symbol
// error correction, and detection of patterns that do not fit a single error.
module rs_decoding_cont (
   input  logic        clk,
   input  logic        rst,
   input  logic [59:0] codeWordVector,
   input  logic        decodeCodeWord,
   output logic        decoderBusy,
   output logic [35:0] message,
   output logic        decodeDone,
   output logic        errorDetected,
   output logic        errorCorrected,
   output logic        uncorrectable,
   output logic [3:0]  errorLocation
);

   typedef enum logic [1:0] {IDLE, SYND, ANALYZE, DONE} state_t;

   // alpha^j for the syndrome roots j=1..6
   localparam logic [6:1][3:0] ALPHA_POW = {4'hC, 4'h6, 4'h3, 4'h8, 4'h4, 4'h2};

   state_t            state, nextState;
   logic [14:0][3:0]  cw;
   logic [6:1][3:0]   syn;
   logic [3:0]        cnt;
   logic              detR, consR;
   logic [3:0]        locR, magR;

   logic [3:0]        xVal, locV, magV;
   logic              consistent;
   logic [14:0][3:0]  fixedCw;

   function automatic logic [3:0] gfMul(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] acc;
      logic [3:0] sh;
      acc = '0;
      sh  = a;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = {sh[2:0], 1'b0} ^ {2'b00, sh[3], sh[3]};
      end
      return acc;
   endfunction

   function automatic logic [3:0] gfInv(input logic [3:0] a);
      logic [3:0] r;
      case (a)
         4'h1: r = 4'h1;  4'h2: r = 4'h9;  4'h3: r = 4'hE;  4'h4: r = 4'hD;
         4'h5: r = 4'hB;  4'h6: r = 4'h7;  4'h7: r = 4'h6;  4'h8: r = 4'hF;
         4'h9: r = 4'h2;  4'hA: r = 4'hC;  4'hB: r = 4'h5;  4'hC: r = 4'hA;
         4'hD: r = 4'h4;  4'hE: r = 4'h3;  4'hF: r = 4'h8;
         default: r = 4'h0;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] gfLog(input logic [3:0] a);
      logic [3:0] r;
      case (a)
         4'h2: r = 4'd1;   4'h3: r = 4'd4;   4'h4: r = 4'd2;   4'h5: r = 4'd8;
         4'h6: r = 4'd5;   4'h7: r = 4'd10;  4'h8: r = 4'd3;   4'h9: r = 4'd14;
         4'hA: r = 4'd9;   4'hB: r = 4'd7;   4'hC: r = 4'd6;   4'hD: r = 4'd13;
         4'hE: r = 4'd11;  4'hF: r = 4'd12;
         default: r = 4'd0;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (decodeCodeWord) nextState = SYND;
         SYND:    if (cnt == 4'd0) nextState = ANALYZE;
         ANALYZE: nextState = DONE;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // A single error at i with value e gives S_j = e*X^j, X = alpha^i.
   always_comb begin
      xVal       = gfMul(syn[2], gfInv(syn[1]));
      consistent = (syn[1] != 4'h0) && (syn[2] != 4'h0) &&
                   (syn[3] == gfMul(syn[2], xVal)) &&
                   (syn[4] == gfMul(syn[3], xVal)) &&
                   (syn[5] == gfMul(syn[4], xVal)) &&
                   (syn[6] == gfMul(syn[5], xVal));
      locV       = gfLog(xVal);
      magV       = gfMul(syn[1], gfInv(xVal));
   end

   always_comb begin
      fixedCw = cw;
      if (consR) fixedCw[locR] = cw[locR] ^ magR;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cw             <= '0;
         syn            <= '0;
         cnt            <= 4'd0;
         detR           <= 1'b0;
         consR          <= 1'b0;
         locR           <= 4'd0;
         magR           <= 4'd0;
         decoderBusy    <= 1'b0;
         message        <= '0;
         decodeDone     <= 1'b0;
         errorDetected  <= 1'b0;
         errorCorrected <= 1'b0;
         uncorrectable  <= 1'b0;
         errorLocation  <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               decodeDone <= 1'b0;
               if (decodeCodeWord) begin
                  cw          <= codeWordVector;
                  syn         <= '0;
                  cnt         <= 4'd14;
                  decoderBusy <= 1'b1;
               end
            end
            SYND: begin
               for (int j = 1; j <= 6; j++)
                  syn[j] <= gfMul(syn[j], ALPHA_POW[j]) ^ cw[cnt];
               if (cnt != 4'd0) cnt <= cnt - 4'd1;
            end
            ANALYZE: begin
               detR  <= (syn != '0);
               consR <= consistent;
               locR  <= consistent ? locV : 4'd0;
               magR  <= consistent ? magV : 4'd0;
            end
            DONE: begin
               message        <= fixedCw[14:6];
               errorDetected  <= detR;
               errorCorrected <= consR;
               uncorrectable  <= detR & ~consR;
               errorLocation  <= locR;
               decodeDone     <= 1'b1;
               decoderBusy    <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rs_decoding_cont.sv
// Randomized bench for rs_decoding_cont: algebraic GF(16) model (log/exp tables,
// brute-force single-error search) plus a per-cycle compare process.
module tb_rs_decoding_cont;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [59:0] codeWordVector = '0;
   logic        decodeCodeWord = 1'b0;
   logic        decoderBusy, decodeDone, errorDetected, errorCorrected, uncorrectable;
   logic [35:0] message;
   logic [3:0]  errorLocation;

   rs_decoding_cont dut (
      .clk(clk), .rst(rst), .codeWordVector(codeWordVector), .decodeCodeWord(decodeCodeWord),
      .decoderBusy(decoderBusy), .message(message), .decodeDone(decodeDone),
      .errorDetected(errorDetected), .errorCorrected(errorCorrected),
      .uncorrectable(uncorrectable), .errorLocation(errorLocation)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;
   int gexp[15];
   int glog[16];
   int gen[7];

   typedef struct {
      int          e0;
      int          dc;
      logic [35:0] msg;
      logic        det, cor, unc;
      logic [3:0]  loc;
   } exp_t;

   exp_t q[$];
   exp_t lastR;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] ex);
      total++;
      if (act !== ex) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, ex, cyc);
      end
   endtask

   function automatic int gmul(input int a, input int b);
      if (a == 0 || b == 0) return 0;
      return gexp[(glog[a] + glog[b]) % 15];
   endfunction

   function automatic int synd(input logic [59:0] w, input int j);
      int s = 0;
      for (int i = 0; i < 15; i++) s ^= gmul(int'(w[4*i +: 4]), gexp[(i*j) % 15]);
      return s;
   endfunction

   function automatic exp_t model(input logic [59:0] w);
      exp_t r;
      int s[7];
      logic any;
      logic ok;
      logic [59:0] fixed;
      r = '{default: 0};
      any = 1'b0;
      for (int j = 1; j <= 6; j++) begin
         s[j] = synd(w, j);
         if (s[j] != 0) any = 1'b1;
      end
      r.msg = w[59:24];
      r.det = any;
      if (any) begin
         for (int i = 0; i < 15; i++)
            for (int e = 1; e < 16; e++) begin
               ok = 1'b1;
               for (int j = 1; j <= 6; j++)
                  if (gmul(e, gexp[(i*j) % 15]) != s[j]) ok = 1'b0;
               if (ok) begin
                  r.cor = 1'b1;
                  r.loc = 4'(i);
                  fixed = w;
                  fixed[4*i +: 4] ^= 4'(e);
                  r.msg = fixed[59:24];
               end
            end
         r.unc = !r.cor;
      end
      return r;
   endfunction

   function automatic logic [59:0] encode(input logic [35:0] m);
      int rem[6];
      int fb;
      logic [59:0] w;
      for (int k = 0; k < 6; k++) rem[k] = 0;
      for (int i = 8; i >= 0; i--) begin
         fb = int'(m[4*i +: 4]) ^ rem[5];
         for (int k = 5; k >= 1; k--) rem[k] = rem[k-1] ^ gmul(fb, gen[k]);
         rem[0] = gmul(fb, gen[0]);
      end
      w = '0;
      w[59:24] = m;
      for (int k = 0; k < 6; k++) w[4*k +: 4] = 4'(rem[k]);
      return w;
   endfunction

   // Compare process: busy/done timing and held result outputs, every cycle.
   always begin
      exp_t h;
      logic hasQ, expBusy, expDone;
      @(posedge clk);
      #1;
      hasQ = (q.size() > 0);
      h = '{default: 0};
      if (hasQ) h = q[0];
      expBusy = hasQ && (cyc >= h.e0) && (cyc < h.dc);
      expDone = hasQ && (cyc == h.dc);
      chk("busy", decoderBusy, expBusy);
      chk("done", decodeDone, expDone);
      if (expDone) begin
         lastR = h;
         void'(q.pop_front());
      end
      chk("message", message, lastR.msg);
      chk("errorDetected", errorDetected, lastR.det);
      chk("errorCorrected", errorCorrected, lastR.cor);
      chk("uncorrectable", uncorrectable, lastR.unc);
      chk("errorLocation", errorLocation, lastR.loc);
   end

   // Called at a negedge; the request is sampled on the next posedge (E0).
   task automatic launch(input logic [59:0] w, input int hold);
      exp_t e;
      logic [63:0] junk;
      e = model(w);
      e.e0 = cyc + 1;
      e.dc = cyc + 18;
      q.push_back(e);
      codeWordVector = w;
      decodeCodeWord = 1'b1;
      @(negedge clk);
      repeat (hold) @(negedge clk);
      decodeCodeWord = 1'b0;
      junk = {$urandom(), $urandom()};
      codeWordVector = junk[59:0];
   endtask

   initial begin
      exp_t e;
      logic [59:0] w;
      logic [63:0] r;
      logic [35:0] lit;
      int v, hold, gap, nerr, p;

      lastR = '{default: 0};
      v = 1;
      glog[0] = 0;
      for (int i = 0; i < 15; i++) begin
         gexp[i] = v;
         glog[v] = i;
         v = v << 1;
         if ((v & 16) != 0) v ^= 19;
      end
      for (int k = 0; k < 7; k++) gen[k] = 0;
      gen[0] = 1;
      for (int j = 1; j <= 6; j++) begin
         for (int k = j; k >= 1; k--) gen[k] = gen[k-1] ^ gmul(gen[k], gexp[j]);
         gen[0] = gmul(gen[0], gexp[j]);
      end

      // Hand-derived values that pin the model
      chk("pin_gen6", gen[6], 1);
      chk("pin_gen0", gen[0], 12);
      w = '0; w[43:40] = 4'h5;
      e = model(w);
      chk("pin_sym10_loc", e.loc, 10);
      chk("pin_sym10_cor", e.cor, 1);
      w = '0; w[3:0] = 4'h1; w[59:56] = 4'h1;
      e = model(w);
      chk("pin_s1", synd(w, 1), 8);
      chk("pin_s2", synd(w, 2), 12);
      chk("pin_two_unc", e.unc, 1);
      lit = 36'h100000000;
      chk("pin_two_msg", e.msg, lit);

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      launch(60'h0, 0);                        repeat (17) @(negedge clk);
      w = '0; w[43:40] = 4'h5; launch(w, 0);   repeat (17) @(negedge clk);
      w = '0; w[11:8]  = 4'h9; launch(w, 0);   repeat (17) @(negedge clk);
      w = '0; w[3:0] = 4'h1; w[59:56] = 4'h1;
      launch(w, 0);                            repeat (17) @(negedge clk);

      // Stray request at E5, then back-to-back request at E18
      r = {$urandom(), $urandom()};
      w = encode(r[35:0]); w[27:24] ^= 4'h7;
      launch(w, 0);
      repeat (4) @(negedge clk);
      decodeCodeWord = 1'b1;
      @(negedge clk);
      decodeCodeWord = 1'b0;
      repeat (12) @(negedge clk);
      r = {$urandom(), $urandom()};
      launch(encode(r[35:0]), 0);              repeat (17) @(negedge clk);

      // Request held through the done edge: only one decode
      launch(60'h0123456789ABCDE, 17);
      repeat (2) @(negedge clk);

      // Abort by reset mid-decode
      launch(60'hFEDCBA987654321, 0);
      repeat (7) @(negedge clk);
      rst = 1'b1;
      q.delete();
      lastR = '{default: 0};
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      launch(60'h0, 0);                        repeat (17) @(negedge clk);

      for (int n = 0; n < 40; n++) begin
         r = {$urandom(), $urandom()};
         w = encode(r[35:0]);
         for (int j = 1; j <= 6; j++) chk("enc_synd", synd(w, j), 0);
         nerr = $urandom_range(0, 3);
         if (nerr == 3) begin
            r = {$urandom(), $urandom()};
            w = r[59:0];
         end else begin
            for (int k = 0; k < nerr; k++) begin
               p = $urandom_range(0, 14);
               w[4*p +: 4] ^= 4'($urandom_range(1, 15));
            end
         end
         hold = $urandom_range(0, 2);
         gap  = $urandom_range(0, 3);
         launch(w, hold);
         repeat (17 - hold + gap) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rs_decoding_cont.md
# rs_decoding_cont

Receive-side counterpart of the RS(15,9) encoding controller. It accepts a 60-bit codeword over GF(16) (15 four-bit symbols) on a single-cycle request and computes the six syndromes serially. It corrects any single-symbol error and flags uncorrectable patterns. It returns the 36-bit message with a done pulse and sits between the channel model and the message sink.

## Interface
Parameters:
- None. The code is fixed:
  - n=15, k=9, 4-bit symbols.
  - Field polynomial x^4+x+1; alpha = 4'h2.
  - Generator roots alpha^1..alpha^6.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- codeWordVector  in  60  symbol i (coefficient of X^i) is bits [4i+3:4i].
  - Systematic layout: [59:24] is the message, [23:0] is parity.
- decodeCodeWord  in  1  request strobe; sampled only in IDLE.
- decoderBusy  out  1  high from the edge that accepts a request until the done edge.
- message  out  36  decoded (corrected) codeword bits [59:24]; holds until the next done.
- decodeDone  out  1  one-cycle pulse; all result outputs are valid while it is high.
- errorDetected  out  1  any syndrome is nonzero.
- errorCorrected  out  1  single-symbol error located and fixed.
- uncorrectable  out  1  nonzero syndromes that are inconsistent with one error.
- errorLocation  out  4  symbol index of the corrected error; 0 when errorCorrected=0.

## Operation
- **Reset** drives every output to 0 (including message) and the FSM to IDLE; the syndrome registers and the latched codeword are cleared.
- **IDLE:**
  - On decodeCodeWord=1, latch codeWordVector, clear S1..S6 and the symbol counter (cnt=14), then go to SYND.
  - While not in IDLE, decodeCodeWord is ignored; there is no queuing.
- **SYND**, 15 cycles, Horner evaluation highest symbol first:
  - Each cycle: S_j <= S_j*alpha^j XOR c_cnt for j=1..6, then cnt decrements.
  - Leave SYND after c_0 is absorbed (cnt=0).
  - Constant-multiplier GF(16) logic only.
- **ANALYZE**, 1 cycle:
  - All S_j=0: no error.
  - Else, if S1≠0 and S2≠0: compute X = S2*inv(S1), with inv from a 16-entry LUT.
    - The pattern is consistent if S_{j+1} = S_j*X for j=2..5.
    - If consistent: location i = log(X) (LUT, 0..14) and magnitude Y = S1*inv(X).
  - Any other nonzero case is uncorrectable.
- **DONE**, 1 cycle:
  - Apply the correction, c_i ^= Y, only when consistent.
  - Register message and the flags; pulse decodeDone; drop decoderBusy; return to IDLE.
- **Uncorrectable:** message = raw latched bits [59:24]; errorCorrected=0.
- **Parity-symbol errors (i<6)** are corrected and flagged, but message is unaffected.
- Flags are mutually consistent:
  - errorCorrected and uncorrectable are never both 1.
  - Either one implies errorDetected.
- Patterns with ≥2 errors that alias a single-error syndrome are miscorrected; this is inherent to t=1 correction and not a bug.

## Timing
- Request sampled at edge E0; decoderBusy=1 after E0.
- SYND occupies E1..E15 and ANALYZE E16.
- At E17: results are registered, decodeDone=1 for that one cycle, and decoderBusy=0.
- Latency is 17 clocks from request to done.
- A new request sampled at E18 is accepted (back-to-back period 18 clocks).
- decodeDone stays 0 after E18 unless a new decode completes.
- codeWordVector may change after E0 without affecting the result.
- A request held high for multiple cycles in IDLE starts exactly one decode.
- If a request coincides with the done edge, it is ignored (FSM not yet in IDLE).
- rst asserted mid-decode aborts immediately:
  - Outputs go to 0 asynchronously; no decodeDone is issued.
  - After release, the block is in IDLE and accepts the next request.

## Test plan
- Codeword all zeros, request -> at E17: decodeDone=1, message=36'h0, errorDetected=0, errorCorrected=0, uncorrectable=0; busy high exactly cycles E1..E16.
- Zero codeword with symbol 10 = 4'h5 (bits [43:40]) -> message=36'h0, errorDetected=1, errorCorrected=1, errorLocation=10.
- Zero codeword with symbol 2 = 4'h9 -> errorCorrected=1, errorLocation=2, message=36'h0.
- Zero codeword with symbols 0 and 14 = 4'h1 -> S1=4'h8 and S2=4'hC, consistency fails at S3 -> uncorrectable=1, errorCorrected=0, message=36'h100000000 (raw).
- Second request pulsed at E5 during a decode -> ignored, exactly one decodeDone. Request at E18 -> accepted, done at E35.
- rst pulsed at E8 of a decode -> all outputs 0, no decodeDone. Following zero-codeword request -> normal done 17 clocks later.
